fifo_sample_packer: RTL and testbench
=====================================

Name: fifo_sample_packer

Overview:
- Upstream feeder for the synchronous FIFO in the capture path.
- Collects narrow samples, e.g. ADC or trace data, into FIFO-width words.
- Issues one write per completed word and never writes into a full FIFO.
- Handles partial-word flush, drop accounting and a per-capture word count. The FIFO's write side is driven directly from this block.

Parameters:
- pIN_WIDTH, 8: bits per input sample.
- pRATIO, 4: samples per output word, ≥1. The output width is pIN_WIDTH*pRATIO, computed internally, not overridable.
- pCOUNT_WIDTH, 32: width of word_count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  capture armed; level
- in_valid  in  1  in_data valid this cycle
- in_data  in  pIN_WIDTH  sample
- flush  in  1  single-cycle pulse: push out the pending partial word
- fifo_full  in  1  from FIFO full
- fifo_almost_full  in  1  from FIFO almost_full
- fifo_wen  out  1  FIFO write enable, registered
- fifo_wdata  out  pIN_WIDTH*pRATIO  FIFO write data, registered
- busy  out  1  partial word held or write in flight
- dropped  out  1  sticky: at least one word lost to full
- word_count  out  pCOUNT_WIDTH  words written this capture
- drop_count  out  16  dropped words, saturating; see Optional Feature

Behaviour:
- Reset (async, rst_n low):
  - State IDLE, slot index 0, pack register 0.
  - fifo_wen=0, fifo_wdata=0, busy=0, dropped=0, word_count=0, drop_count=0.
  - Reset mid-word discards all pending samples.
- FSM states: IDLE, PACK.
  - IDLE→PACK when enable=1. On this transition, clear slot index, dropped, word_count and drop_count.
  - PACK→IDLE when enable=0.
- Packing:
  - In PACK, each in_valid stores in_data in slot idx, bits [idx*pIN_WIDTH +: pIN_WIDTH]. The first sample sits in the LSBs.
  - idx increments and wraps to 0 after pRATIO-1. in_valid in IDLE is ignored.
- Completion:
  - When the sample that fills slot pRATIO-1 is accepted at cycle t, the word is issued at t+1: fifo_wen=1 for exactly one cycle and fifo_wdata = assembled word.
  - The next sample may arrive at t and goes to slot 0. Full throughput is one sample per cycle with no stalls.
- Full rule:
  - A word is dropped when `fifo_full || (fifo_wen && fifo_almost_full)` at the completion cycle. The second term covers a write still in flight.
  - On a drop: fifo_wen stays 0, dropped←1, word_count unchanged.
  - fifo_wen is never asserted into a full FIFO.
- Flush:
  - flush in PACK with idx>0 issues the partial word next cycle. Unused upper slots are zero; the full rule applies. idx then returns to 0.
  - flush with idx=0 has no effect. flush in IDLE has no effect.
- Simultaneous events:
  - in_valid and flush in the same cycle: the sample is stored first, then the flush applies.
  - If that sample completes the word, exactly one write is issued, with no extra empty write.
  - enable falling with flush in the same cycle: the flush is honoured, then IDLE.
  - enable falling without flush: the partial word is discarded and no write is issued.
- word_count increments on every issued write, including partial words, and wraps at 2^pCOUNT_WIDTH.
- busy = (idx≠0) || fifo_wen.
- fifo_wdata holds its last value when fifo_wen=0.

Optional Feature:
- Macro: PACKER_DROP_COUNT_EN.
- Defined:
  - drop_count increments on each dropped word and saturates at 0xFFFF.
  - It is cleared on reset and on IDLE→PACK.
- Undefined: drop_count is tied to 0 and no counter logic is instantiated. All other behaviour is identical.

Test Plan:
- Defaults, enable=1, samples 0x11,0x22,0x33,0x44 on consecutive cycles → one cycle after 0x44, fifo_wen=1 for one cycle, fifo_wdata=0x44332211, word_count=1, busy=0 afterwards.
- Samples 0xAA,0xBB then flush pulse → next cycle fifo_wen=1, fifo_wdata=0x0000BBAA, word_count=1. A second flush → no write.
- fifo_full=1, 8 samples → fifo_wen never 1, dropped=1, word_count=0. drop_count=2 with the macro defined, 0 without.
- pRATIO=1, continuous in_valid, fifo_almost_full=1 while fifo_wen=1 → the word after the in-flight write is dropped, with no back-to-back write into the last slot.
- 3 samples, then 4th sample and flush in the same cycle → exactly one write, 0x44332211; no zero word follows.
- 2 samples, then rst_n low mid-word → all outputs 0 immediately. After release and enable, 0x01..0x04 yields 0x04030201 with no stale data. Dropping enable with 3 pending → no write. Re-enable clears word_count and dropped.

Source files
------------

// File: rtl/fifo_sample_packer.sv
// Packs pIN_WIDTH-bit samples into pIN_WIDTH*pRATIO-bit words and writes them into a synchronous FIFO.
// Optional saturating drop counter is built only when PACKER_DROP_COUNT_EN is defined.
module fifo_sample_packer #(
  parameter int pIN_WIDTH    = 8,
  parameter int pRATIO       = 4,
  parameter int pCOUNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          in_valid,
  input  logic [pIN_WIDTH-1:0]          in_data,
  input  logic                          flush,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wen,
  output logic [pIN_WIDTH*pRATIO-1:0]   fifo_wdata,
  output logic                          busy,
  output logic                          dropped,
  output logic [pCOUNT_WIDTH-1:0]       word_count,
  output logic [15:0]                   drop_count
);

  localparam int OUT_W = pIN_WIDTH * pRATIO;
  localparam int IDX_W = (pRATIO > 1) ? $clog2(pRATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(pRATIO - 1);

  typedef enum logic {IDLE, PACK} state_t;

  state_t                  r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic [OUT_W-1:0]        r_pack, w_pack_nxt, w_word;
  logic                    r_wen;
  logic [OUT_W-1:0]        r_wdata;
  logic                    r_dropped;
  logic [pCOUNT_WIDTH-1:0] r_word_count;
  logic                    w_start, w_in_pack, w_take, w_complete, w_has_partial;
  logic                    w_flush_word, w_issue, w_drop, w_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable)  w_state_nxt = PACK;
      PACK:    if (!enable) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FIFO write side: fifo_wen is a one-cycle strobe with fifo_wdata valid in the same cycle;
  // there is no ready, so a word is dropped instead of written whenever the FIFO may be full.
  always_comb begin
    w_start   = (r_state == IDLE) && enable;
    w_in_pack = (r_state == PACK);
    w_take    = w_in_pack && in_valid;
    w_word    = r_pack;
    if (w_take) w_word[r_idx*pIN_WIDTH +: pIN_WIDTH] = in_data;
    w_complete    = w_take && (r_idx == IDX_LAST);
    w_has_partial = w_take || (r_idx != '0);
    // A sample that completes the word absorbs a simultaneous flush.
    w_flush_word  = w_in_pack && flush && !w_complete && w_has_partial;
    w_issue       = w_complete || w_flush_word;
    w_drop        = w_issue && (fifo_full || (r_wen && fifo_almost_full));
    w_write       = w_issue && !w_drop;
    w_idx_nxt     = r_idx;
    w_pack_nxt    = r_pack;
    if (w_start) begin
      w_idx_nxt  = '0;
      w_pack_nxt = '0;
    end else if (w_in_pack) begin
      if (w_issue || !enable) begin
        w_idx_nxt  = '0;
        w_pack_nxt = '0;
      end else if (w_take) begin
        w_idx_nxt  = r_idx + 1'b1;
        w_pack_nxt = w_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_pack       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_dropped    <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_pack <= w_pack_nxt;
      r_wen  <= w_write;
      if (w_write) r_wdata <= w_word;
      if (w_start)     r_dropped <= 1'b0;
      else if (w_drop) r_dropped <= 1'b1;
      if (w_start)      r_word_count <= '0;
      else if (w_write) r_word_count <= r_word_count + 1'b1;
    end
  end

`ifdef PACKER_DROP_COUNT_EN
  logic [15:0] r_drop_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_drop_count <= '0;
    else if (w_start)                            r_drop_count <= '0;
    else if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 1'b1;
  end
  assign drop_count = r_drop_count;
`else
  assign drop_count = '0;
`endif

  assign fifo_wen   = r_wen;
  assign fifo_wdata = r_wdata;
  assign busy       = (r_idx != '0) || r_wen;
  assign dropped    = r_dropped;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_fifo_sample_packer.sv
// Directed bench: default 4x8 packer plus a 1x8 instance for the in-flight write / almost_full case.
module tb_fifo_sample_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, in_valid, flush, fifo_full, fifo_almost_full;
  logic [7:0]  in_data;
  logic        fifo_wen, busy, dropped;
  logic [31:0] fifo_wdata, word_count;
  logic [15:0] drop_count;

  logic        b_enable, b_valid, b_flush, b_full, b_afull;
  logic [7:0]  b_data;
  logic        b_wen, b_busy, b_dropped;
  logic [7:0]  b_wdata;
  logic [31:0] b_word_count;
  logic [15:0] b_drop_count;

  logic [31:0] exp_q[$];
  logic [7:0]  exp_b_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

`ifdef PACKER_DROP_COUNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  fifo_sample_packer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
    .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .busy(busy), .dropped(dropped),
    .word_count(word_count), .drop_count(drop_count)
  );

  assign b_afull = b_wen;

  fifo_sample_packer #(.pIN_WIDTH(8), .pRATIO(1), .pCOUNT_WIDTH(32)) dut_r1 (
    .clk(clk), .rst_n(rst_n), .enable(b_enable), .in_valid(b_valid), .in_data(b_data),
    .flush(b_flush), .fifo_full(b_full), .fifo_almost_full(b_afull),
    .fifo_wen(b_wen), .fifo_wdata(b_wdata), .busy(b_busy), .dropped(b_dropped),
    .word_count(b_word_count), .drop_count(b_drop_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitors: every observed write must match the head of its expected queue.
  always @(negedge clk) begin
    if (rst_n && fifo_wen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got %0h expected no write", fifo_wdata);
      end else begin
        check("wdata", {32'h0, fifo_wdata}, {32'h0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_wen) begin
      if (exp_b_q.size() == 0) begin
        n_checks++;
        $display("FAIL r1_unexpected_write: got %0h expected no write", b_wdata);
      end else begin
        check("r1_wdata", {56'h0, b_wdata}, {56'h0, exp_b_q.pop_front()});
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic f);
    in_valid = v; in_data = d; flush = f;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic rearm();
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
    fifo_full = 1'b0; fifo_almost_full = 1'b0;
    b_enable = 1'b0; b_valid = 1'b0; b_data = '0; b_flush = 1'b0; b_full = 1'b0;
    step(3);
    check("rst_wen", {63'h0, fifo_wen}, 64'h0);
    check("rst_wdata", {32'h0, fifo_wdata}, 64'h0);
    check("rst_busy_dropped", {62'h0, busy, dropped}, 64'h0);
    check("rst_counts", {16'h0, drop_count, word_count}, 64'h0);
    rst_n = 1'b1;
    step(1);

    // Full word
    enable = 1'b1;
    step(1);
    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0);
    exp_q.push_back(32'h44332211);
    cyc(1, 8'h44, 0);
    check("t1_wen", {63'h0, fifo_wen}, 64'h1);
    check("t1_word_count", {32'h0, word_count}, 64'd1);
    step(1);
    check("t1_busy_after", {62'h0, busy, fifo_wen}, 64'h0);

    // Partial flush, then a flush with nothing pending
    rearm();
    cyc(1, 8'hAA, 0); cyc(1, 8'hBB, 0);
    check("t2_busy_partial", {63'h0, busy}, 64'h1);
    exp_q.push_back(32'h0000BBAA);
    cyc(0, 8'h00, 1);
    check("t2_wen", {63'h0, fifo_wen}, 64'h1);
    check("t2_word_count", {32'h0, word_count}, 64'd1);
    cyc(0, 8'h00, 1);
    step(2);
    check("t2_word_count_after", {32'h0, word_count}, 64'd1);

    // FIFO full: two words dropped
    rearm();
    fifo_full = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1, 8'(i + 1), 0);
    fifo_full = 1'b0;
    step(1);
    check("t3_dropped", {63'h0, dropped}, 64'h1);
    check("t3_word_count", {32'h0, word_count}, 64'd0);
    check("t3_drop_count", {48'h0, drop_count}, DC_EN ? 64'd2 : 64'd0);

    // Last sample with flush in the same cycle
    rearm();
    check("t5_rearm_clear", {31'h0, dropped, word_count}, 64'h0);
    check("t5_rearm_drop_count", {48'h0, drop_count}, 64'h0);
    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0);
    exp_q.push_back(32'h44332211);
    cyc(1, 8'h44, 1);
    step(3);
    check("t5_word_count", {32'h0, word_count}, 64'd1);

    // Asynchronous reset mid-word
    cyc(1, 8'h01, 0); cyc(1, 8'h02, 0);
    check("t6_busy_before_rst", {63'h0, busy}, 64'h1);
    rst_n = 1'b0; enable = 1'b0;
    #1;
    check("t6_rst_wdata", {32'h0, fifo_wdata}, 64'h0);
    check("t6_rst_flags", {61'h0, fifo_wen, busy, dropped}, 64'h0);
    check("t6_rst_counts", {16'h0, drop_count, word_count}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    enable = 1'b1;
    step(1);
    cyc(1, 8'h01, 0); cyc(1, 8'h02, 0); cyc(1, 8'h03, 0);
    exp_q.push_back(32'h04030201);
    cyc(1, 8'h04, 0);
    step(1);
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1, 8'hE0 + 8'(i), 0);
    fifo_full = 1'b0;
    cyc(1, 8'h05, 0); cyc(1, 8'h06, 0); cyc(1, 8'h07, 0);
    enable = 1'b0;
    step(3);
    check("t6_dropped", {63'h0, dropped}, 64'h1);
    check("t6_word_count", {32'h0, word_count}, 64'd1);
    check("t6_busy_discard", {63'h0, busy}, 64'h0);
    enable = 1'b1;
    step(1);
    check("t6_reenable_clear", {31'h0, dropped, word_count}, 64'h0);
    check("t6_reenable_drop_count", {48'h0, drop_count}, 64'h0);
    enable = 1'b0;
    step(1);

    // pRATIO=1 with almost_full following fifo_wen: alternate words are dropped
    b_enable = 1'b1;
    step(1);
    exp_b_q.push_back(8'h01); exp_b_q.push_back(8'h03); exp_b_q.push_back(8'h05);
    for (int i = 0; i < 6; i++) begin
      b_valid = 1'b1; b_data = 8'(i + 1);
      @(negedge clk);
    end
    b_valid = 1'b0;
    step(3);
    check("r1_word_count", {32'h0, b_word_count}, 64'd3);
    check("r1_dropped", {63'h0, b_dropped}, 64'h1);
    check("r1_drop_count", {48'h0, b_drop_count}, DC_EN ? 64'd3 : 64'd0);

    check("queue_empty", {32'h0, 32'(exp_q.size())}, 64'h0);
    check("r1_queue_empty", {32'h0, 32'(exp_b_q.size())}, 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
